// File: rtl/match_index_collector.sv
// Collects filtered rule indices for one packet, drops duplicates, and then
// drains the unique hits in first-hit order over a valid/ready handshake.
module match_index_collector #(
    parameter int IDX_W = 11,
    parameter int DEPTH = 16,
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             pkt_start,
    input  logic             pkt_end,
    input  logic [IDX_W-1:0] index_in,
    output logic             busy,
    output logic             result_valid,
    input  logic             result_ready,
    output logic [IDX_W-1:0] result_index,
    output logic             result_last,
    output logic [CNT_W-1:0] hit_count,
    output logic             overflow,
    output logic             pkt_err
);

    localparam int PTR_W = $clog2(DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_DRAIN} state_e;

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   entries_q [DEPTH];
    logic [CNT_W-1:0]   hit_count_q, hit_count_d;
    logic               overflow_q, overflow_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic               pkt_err_q, pkt_err_d;

    logic               wr_en;
    logic [PTR_W-1:0]   wr_addr;
    logic               is_dup;
    logic               is_full;
    logic               is_last;

    // Only entries below hit_count are live; stale slots must never match.
    always_comb begin
        is_dup = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (CNT_W'(i) < hit_count_q && entries_q[i] == index_in) begin
                is_dup = 1'b1;
            end
        end
    end

    assign is_full = (hit_count_q == CNT_W'(DEPTH));
    assign is_last = (hit_count_q == '0) || (CNT_W'(rd_ptr_q) == hit_count_q - CNT_W'(1));

    // NOTE: every signal gets a default first so no path leaves one unassigned (no latches).
    always_comb begin
        state_d     = state_q;
        hit_count_d = hit_count_q;
        overflow_d  = overflow_q;
        rd_ptr_d    = rd_ptr_q;
        pkt_err_d   = 1'b0;
        wr_en       = 1'b0;
        wr_addr     = hit_count_q[PTR_W-1:0];

        case (state_q)
            S_IDLE, S_COLLECT: begin
                if (pkt_start) begin
                    // New packet (or restart): the list collapses to the same-cycle index.
                    wr_en       = (index_in != '0);
                    wr_addr     = '0;
                    hit_count_d = CNT_W'(index_in != '0);
                    overflow_d  = 1'b0;
                    rd_ptr_d    = '0;
                    state_d     = pkt_end ? S_DRAIN : S_COLLECT;
                end else if (state_q == S_COLLECT) begin
                    if (index_in != '0 && !is_dup) begin
                        if (is_full) begin
                            overflow_d = 1'b1;
                        end else begin
                            wr_en       = 1'b1;
                            hit_count_d = hit_count_q + CNT_W'(1);
                        end
                    end
                    if (pkt_end) begin
                        state_d = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                pkt_err_d = pkt_start;
                if (result_ready) begin
                    if (is_last) begin
                        rd_ptr_d = '0;
                        state_d  = S_IDLE;
                    end else begin
                        rd_ptr_d = rd_ptr_q + PTR_W'(1);
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: non-blocking assignments for all state so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            hit_count_q <= '0;
            overflow_q  <= 1'b0;
            rd_ptr_q    <= '0;
            pkt_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            hit_count_q <= hit_count_d;
            overflow_q  <= overflow_d;
            rd_ptr_q    <= rd_ptr_d;
            pkt_err_q   <= pkt_err_d;
        end
    end

    // NOTE: the entry store has no reset; hit_count alone decides which entries are valid.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            entries_q[wr_addr] <= index_in;
        end
    end

    assign busy         = (state_q == S_DRAIN);
    assign result_valid = (state_q == S_DRAIN);
    assign result_index = (result_valid && hit_count_q != '0) ? entries_q[rd_ptr_q] : '0;
    assign result_last  = result_valid && is_last;
    assign hit_count    = hit_count_q;
    assign overflow     = overflow_q;
    assign pkt_err      = pkt_err_q;

endmodule

// File: tb/tb_match_index_collector.sv
// Directed bench for match_index_collector: each task drives one scenario and
// checks its outputs against hand-computed values.
module tb_match_index_collector;

    logic        clk;
    logic        reset;
    logic        pkt_start;
    logic        pkt_end;
    logic [10:0] index_in;
    logic        busy;
    logic        result_valid;
    logic        result_ready;
    logic [10:0] result_index;
    logic        result_last;
    logic [4:0]  hit_count;
    logic        overflow;
    logic        pkt_err;

    int n_cmp = 0;
    int n_err = 0;

    logic [10:0] got_idx  [0:31];
    logic        got_last [0:31];
    int          got_n;
    bit          got_to;
    logic [10:0] v [0:19];

    match_index_collector #(.IDX_W(11), .DEPTH(16), .CNT_W(5)) dut (
        .clk          (clk),
        .reset        (reset),
        .pkt_start    (pkt_start),
        .pkt_end      (pkt_end),
        .index_in     (index_in),
        .busy         (busy),
        .result_valid (result_valid),
        .result_ready (result_ready),
        .result_index (result_index),
        .result_last  (result_last),
        .hit_count    (hit_count),
        .overflow     (overflow),
        .pkt_err      (pkt_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drives one packet: pkt_start on the first value, pkt_end on the last.
    task automatic send_pkt(input int n);
        for (int k = 0; k < n; k++) begin
            pkt_start = (k == 0);
            pkt_end   = (k == n - 1);
            index_in  = v[k];
            tick();
        end
        pkt_start = 1'b0;
        pkt_end   = 1'b0;
        index_in  = '0;
    endtask

    // Records every beat until result_last is accepted, bounded to 64 cycles.
    task automatic drain_collect();
        got_n  = 0;
        got_to = 1'b1;
        for (int k = 0; k < 32; k++) begin
            got_idx[k]  = '1;
            got_last[k] = 1'bx;
        end
        result_ready = 1'b1;
        for (int c = 0; c < 64; c++) begin
            if (result_valid) begin
                if (got_n < 32) begin
                    got_idx[got_n]  = result_index;
                    got_last[got_n] = result_last;
                end
                got_n++;
                if (result_last) begin
                    tick();
                    got_to = 1'b0;
                    break;
                end
            end
            tick();
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        n_cmp++;
        if ({result_valid, busy, result_index, result_last, hit_count, overflow, pkt_err} !== 21'd0) begin
            n_err++;
            $display("FAIL reset_outputs: got valid=%b busy=%b idx=%0d last=%b cnt=%0d ovf=%b err=%b, want all 0",
                     result_valid, busy, result_index, result_last, hit_count, overflow, pkt_err);
        end
    endtask

    task automatic test_basic(input string tag);
        logic [10:0] exp [0:2];
        exp[0] = 11'd5; exp[1] = 11'd9; exp[2] = 11'd12;
        v = '{default: '0};
        v[0] = 11'd5; v[1] = 11'd0; v[2] = 11'd9; v[3] = 11'd5; v[4] = 11'd12; v[5] = 11'd0;
        result_ready = 1'b1;
        send_pkt(6);
        n_cmp++;
        if (busy !== 1'b1 || hit_count !== 5'd3 || overflow !== 1'b0) begin
            n_err++;
            $display("FAIL %s_status: busy=%b cnt=%0d ovf=%b, want busy=1 cnt=3 ovf=0", tag, busy, hit_count, overflow);
        end
        drain_collect();
        n_cmp++;
        if (got_to || got_n != 3) begin
            n_err++;
            $display("FAIL %s_beats: got %0d beats (timeout=%b), want 3", tag, got_n, got_to);
        end
        for (int k = 0; k < 3; k++) begin
            n_cmp++;
            if (got_idx[k] !== exp[k] || got_last[k] !== (k == 2)) begin
                n_err++;
                $display("FAIL %s_beat%0d: idx=%0d last=%b, want idx=%0d last=%b", tag, k, got_idx[k], got_last[k], exp[k], k == 2);
            end
        end
        n_cmp++;
        if (result_valid !== 1'b0 || busy !== 1'b0 || hit_count !== 5'd3) begin
            n_err++;
            $display("FAIL %s_after: valid=%b busy=%b cnt=%0d, want 0 0 3", tag, result_valid, busy, hit_count);
        end
    endtask

    task automatic test_single_cycle();
        v = '{default: '0};
        v[0] = 11'd7;
        send_pkt(1);
        drain_collect();
        n_cmp++;
        if (got_to || got_n != 1 || got_idx[0] !== 11'd7 || got_last[0] !== 1'b1 || hit_count !== 5'd1) begin
            n_err++;
            $display("FAIL single_7: beats=%0d idx=%0d last=%b cnt=%0d, want 1 beat idx=7 last=1 cnt=1",
                     got_n, got_idx[0], got_last[0], hit_count);
        end
        v[0] = 11'd0;
        send_pkt(1);
        drain_collect();
        n_cmp++;
        if (got_to || got_n != 1 || got_idx[0] !== 11'd0 || got_last[0] !== 1'b1 || hit_count !== 5'd0) begin
            n_err++;
            $display("FAIL single_0: beats=%0d idx=%0d last=%b cnt=%0d, want 1 beat idx=0 last=1 cnt=0",
                     got_n, got_idx[0], got_last[0], hit_count);
        end
    endtask

    task automatic test_overflow();
        for (int k = 0; k < 20; k++) v[k] = 11'(k + 1);
        send_pkt(20);
        n_cmp++;
        if (hit_count !== 5'd16 || overflow !== 1'b1) begin
            n_err++;
            $display("FAIL ovf_status: cnt=%0d ovf=%b, want cnt=16 ovf=1", hit_count, overflow);
        end
        drain_collect();
        n_cmp++;
        if (got_to || got_n != 16) begin
            n_err++;
            $display("FAIL ovf_beats: got %0d beats (timeout=%b), want 16", got_n, got_to);
        end
        for (int k = 0; k < 16; k++) begin
            n_cmp++;
            if (got_idx[k] !== 11'(k + 1) || got_last[k] !== (k == 15)) begin
                n_err++;
                $display("FAIL ovf_beat%0d: idx=%0d last=%b, want idx=%0d last=%b", k, got_idx[k], got_last[k], k + 1, k == 15);
            end
        end
        n_cmp++;
        if (overflow !== 1'b1 || hit_count !== 5'd16) begin
            n_err++;
            $display("FAIL ovf_hold: cnt=%0d ovf=%b after drain, want 16 1", hit_count, overflow);
        end
    endtask

    task automatic test_stall();
        v = '{default: '0};
        v[0] = 11'd3; v[1] = 11'd4; v[2] = 11'd5; v[3] = 11'd6;
        result_ready = 1'b1;
        send_pkt(4);
        n_cmp++;
        if (result_valid !== 1'b1 || result_index !== 11'd3 || overflow !== 1'b0 || hit_count !== 5'd4) begin
            n_err++;
            $display("FAIL stall_first: valid=%b idx=%0d ovf=%b cnt=%0d, want 1 3 0 4", result_valid, result_index, overflow, hit_count);
        end
        tick();
        result_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            tick();
            n_cmp++;
            if (result_valid !== 1'b1 || result_index !== 11'd4 || result_last !== 1'b0) begin
                n_err++;
                $display("FAIL stall_hold%0d: valid=%b idx=%0d last=%b, want 1 4 0", c, result_valid, result_index, result_last);
            end
        end
        drain_collect();
        n_cmp++;
        if (got_to || got_n != 3 || got_idx[0] !== 11'd4 || got_idx[1] !== 11'd5 || got_idx[2] !== 11'd6
            || got_last[1] !== 1'b0 || got_last[2] !== 1'b1) begin
            n_err++;
            $display("FAIL stall_rest: beats=%0d idx=%0d,%0d,%0d last2=%b, want 3 beats 4,5,6 last on 6",
                     got_n, got_idx[0], got_idx[1], got_idx[2], got_last[2]);
        end
    endtask

    task automatic test_busy_start();
        v = '{default: '0};
        v[0] = 11'd8; v[1] = 11'd9;
        result_ready = 1'b0;
        send_pkt(2);
        pkt_start = 1'b1;
        index_in  = 11'd33;
        tick();
        pkt_start = 1'b0;
        index_in  = '0;
        n_cmp++;
        if (pkt_err !== 1'b1 || busy !== 1'b1 || hit_count !== 5'd2) begin
            n_err++;
            $display("FAIL busy_err: err=%b busy=%b cnt=%0d, want 1 1 2", pkt_err, busy, hit_count);
        end
        tick();
        n_cmp++;
        if (pkt_err !== 1'b0 || result_index !== 11'd8) begin
            n_err++;
            $display("FAIL busy_err_pulse: err=%b idx=%0d, want err=0 idx=8", pkt_err, result_index);
        end
        drain_collect();
        n_cmp++;
        if (got_to || got_n != 2 || got_idx[0] !== 11'd8 || got_idx[1] !== 11'd9 || got_last[1] !== 1'b1) begin
            n_err++;
            $display("FAIL busy_drain: beats=%0d idx=%0d,%0d last=%b, want 8,9 last=1", got_n, got_idx[0], got_idx[1], got_last[1]);
        end
        v[0] = 11'd10; v[1] = 11'd11;
        send_pkt(2);
        drain_collect();
        n_cmp++;
        if (got_to || got_n != 2 || got_idx[0] !== 11'd10 || got_idx[1] !== 11'd11 || hit_count !== 5'd2) begin
            n_err++;
            $display("FAIL busy_next: beats=%0d idx=%0d,%0d cnt=%0d, want 10,11 cnt=2", got_n, got_idx[0], got_idx[1], hit_count);
        end
    endtask

    task automatic test_mid_reset();
        pkt_start = 1'b1;
        index_in  = 11'd5;
        tick();
        pkt_start = 1'b0;
        index_in  = 11'd6;
        tick();
        index_in  = '0;
        reset     = 1'b1;
        tick();
        reset     = 1'b0;
        n_cmp++;
        if ({result_valid, busy, result_index, result_last, hit_count, overflow, pkt_err} !== 21'd0) begin
            n_err++;
            $display("FAIL reset_collect: valid=%b busy=%b idx=%0d last=%b cnt=%0d ovf=%b err=%b, want all 0",
                     result_valid, busy, result_index, result_last, hit_count, overflow, pkt_err);
        end
        v = '{default: '0};
        v[0] = 11'd1; v[1] = 11'd2;
        result_ready = 1'b0;
        send_pkt(2);
        pkt_start = 1'b1;
        tick();
        pkt_start = 1'b0;
        reset     = 1'b1;
        tick();
        reset     = 1'b0;
        n_cmp++;
        if ({result_valid, busy, result_index, result_last, hit_count, overflow, pkt_err} !== 21'd0) begin
            n_err++;
            $display("FAIL reset_drain: valid=%b busy=%b idx=%0d last=%b cnt=%0d ovf=%b err=%b, want all 0",
                     result_valid, busy, result_index, result_last, hit_count, overflow, pkt_err);
        end
        test_basic("post_reset");
    endtask

    initial begin
        reset        = 1'b1;
        pkt_start    = 1'b0;
        pkt_end      = 1'b0;
        index_in     = '0;
        result_ready = 1'b1;
        v            = '{default: '0};
        test_reset();
        test_basic("basic");
        test_single_cycle();
        test_overflow();
        test_stall();
        test_busy_start();
        test_mid_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
